// File: rtl/up_count_meth_if.sv
// Control and status bundle for up_count_meth.
// master: the side that drives count controls and observes the count.
// slave: the counter itself.
interface up_count_meth_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             ovf_clr;
  logic [WIDTH-1:0] o;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, clr, load, d, ovf_clr,
    input  o, tc, wrap, ovf
  );

  modport slave (
    input  en, clr, load, d, ovf_clr,
    output o, tc, wrap, ovf
  );
endinterface

// File: rtl/up_count_meth.sv
// Modulo-MODULUS up counter with enable, synchronous clear, saturating
// parallel load, terminal count, one-cycle wrap pulse and sticky overflow.
// The count sequence is 0..MODULUS-1. tc is meant for cascading: it is high
// only on the cycle where this stage will wrap, so it can enable the next stage.
module up_count_meth #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16,
  parameter int unsigned INIT    = 0
) (
  input logic            clk,
  input logic            set,
  up_count_meth_if.slave bus
);

  localparam logic [WIDTH-1:0] Term    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt  = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT);

  logic [WIDTH-1:0] o_q, o_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   inc;
  logic             inc_wrap;
  logic [WIDTH-1:0] load_val;

  // Increment stage: one extra bit so MODULUS = 2**WIDTH wraps on the carry out.
  always_comb begin
    inc      = {1'b0, o_q} + (WIDTH + 1)'(1);
    inc_wrap = (inc == ModExt);
    load_val = (bus.d > Term) ? Term : bus.d;
  end

  // Next state, priority clr > load > en; a wrap always beats ovf_clr.
  always_comb begin
    o_d    = o_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (bus.clr) begin
      o_d = '0;
    end else if (bus.load) begin
      o_d = load_val;
    end else if (bus.en) begin
      if (inc_wrap) begin
        o_d    = '0;
        wrap_d = 1'b1;
      end else begin
        o_d = inc[WIDTH-1:0];
      end
    end
    if (wrap_d) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Register stage; set is the asynchronous active-low reset.
  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      o_q    <= InitVal;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      o_q    <= o_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.o    = o_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;
  // Combinational so a cascaded stage sees it in the same cycle.
  assign bus.tc   = (o_q == Term) && bus.en;

endmodule

// File: tb/tb_up_count_meth.sv
// Directed bench for up_count_meth: one default (mod-16) instance and one
// mod-10 instance sharing clock and reset.
module tb_up_count_meth;

  logic clk;
  logic set;

  int n_cmp;
  int n_bad;

  up_count_meth_if #(.WIDTH(4)) bus16 ();
  up_count_meth_if #(.WIDTH(4)) bus10 ();

  up_count_meth #(.WIDTH(4), .MODULUS(16), .INIT(0)) u_dut16 (
    .clk (clk),
    .set (set),
    .bus (bus16)
  );

  up_count_meth #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_dut10 (
    .clk (clk),
    .set (set),
    .bus (bus10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    bus16.en = 1'b0; bus16.clr = 1'b0; bus16.load = 1'b0; bus16.d = '0; bus16.ovf_clr = 1'b0;
  endtask

  task automatic idle10();
    bus10.en = 1'b0; bus10.clr = 1'b0; bus10.load = 1'b0; bus10.d = '0; bus10.ovf_clr = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle16();
    idle10();
    set       = 1'b0;
    bus16.en  = 1'b1;

    // Reset held for two edges with en high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_o", 32'(bus16.o), 0);
      check("rst_wrap", 32'(bus16.wrap), 0);
      check("rst_ovf", 32'(bus16.ovf), 0);
    end
    set = 1'b1;
    tick();
    check("rel_o", 32'(bus16.o), 1);

    // Free run through one full wrap.
    for (int i = 2; i <= 17; i++) begin
      tick();
      check("run_o", 32'(bus16.o), 32'(i % 16));
      check("run_wrap", 32'(bus16.wrap), (i % 16 == 0) ? 1 : 0);
      check("run_tc", 32'(bus16.tc), (i % 16 == 15) ? 1 : 0);
    end
    check("run_ovf", 32'(bus16.ovf), 1);

    // ovf_clr alone clears ovf, count holds.
    idle16();
    bus16.ovf_clr = 1'b1;
    tick();
    check("ovfclr_ovf", 32'(bus16.ovf), 0);
    check("ovfclr_o", 32'(bus16.o), 1);

    // tc gated by en at the terminal value.
    idle16();
    bus16.load = 1'b1; bus16.d = 4'd15;
    tick();
    check("ld15_o", 32'(bus16.o), 15);
    check("tc_en0", 32'(bus16.tc), 0);
    idle16();
    bus16.en = 1'b1;
    #1;
    check("tc_en1", 32'(bus16.tc), 1);

    // Wrap and ovf_clr together: set wins.
    bus16.ovf_clr = 1'b1;
    tick();
    check("wrapclr_o", 32'(bus16.o), 0);
    check("wrapclr_wrap", 32'(bus16.wrap), 1);
    check("wrapclr_ovf", 32'(bus16.ovf), 1);

    // Priority: clr over load over en.
    idle16();
    bus16.load = 1'b1; bus16.d = 4'd5;
    tick();
    check("ld5_o", 32'(bus16.o), 5);
    check("ld5_wrap", 32'(bus16.wrap), 0);
    bus16.clr = 1'b1; bus16.load = 1'b1; bus16.d = 4'd3; bus16.en = 1'b1;
    tick();
    check("clr_o", 32'(bus16.o), 0);
    bus16.clr = 1'b0;
    tick();
    check("ld_en_o", 32'(bus16.o), 3);

    // Load of the terminal value with en set never wraps.
    idle16();
    bus16.ovf_clr = 1'b1;
    tick();
    check("ovf_off", 32'(bus16.ovf), 0);
    idle16();
    bus16.load = 1'b1; bus16.d = 4'd15; bus16.en = 1'b1;
    tick();
    check("lden15_o", 32'(bus16.o), 15);
    check("lden15_wrap", 32'(bus16.wrap), 0);
    check("lden15_ovf", 32'(bus16.ovf), 0);
    bus16.load = 1'b0;
    tick();
    check("wrap2_o", 32'(bus16.o), 0);
    check("wrap2_wrap", 32'(bus16.wrap), 1);
    check("wrap2_ovf", 32'(bus16.ovf), 1);

    // Mod-10 instance: wrap at 9 and saturating load.
    idle16();
    bus10.load = 1'b1; bus10.d = 4'd8;
    tick();
    check("m10_ld8", 32'(bus10.o), 8);
    idle10();
    bus10.en = 1'b1;
    tick();
    check("m10_o9", 32'(bus10.o), 9);
    check("m10_tc", 32'(bus10.tc), 1);
    tick();
    check("m10_o0", 32'(bus10.o), 0);
    check("m10_wrap", 32'(bus10.wrap), 1);
    check("m10_ovf", 32'(bus10.ovf), 1);
    idle10();
    bus10.load = 1'b1; bus10.d = 4'd12; bus10.ovf_clr = 1'b1;
    tick();
    check("m10_sat_o", 32'(bus10.o), 9);
    check("m10_sat_wrap", 32'(bus10.wrap), 0);
    check("m10_sat_ovf", 32'(bus10.ovf), 0);
    check("m10_tc_en0", 32'(bus10.tc), 0);
    idle10();
    bus10.en = 1'b1;
    tick();
    check("m10_o0b", 32'(bus10.o), 0);
    check("m10_wrapb", 32'(bus10.wrap), 1);

    // Stage for asynchronous reset: mod-16 at 7 with ovf set, mod-10 wrapping.
    idle10();
    bus16.load = 1'b1; bus16.d = 4'd7;
    bus10.load = 1'b1; bus10.d = 4'd9;
    tick();
    idle16();
    idle10();
    bus10.en = 1'b1;
    tick();
    check("pre_o16", 32'(bus16.o), 7);
    check("pre_ovf16", 32'(bus16.ovf), 1);
    check("pre_wrap10", 32'(bus10.wrap), 1);
    bus16.en = 1'b1;
    #2;
    set = 1'b0;
    #1;
    check("arst_o16", 32'(bus16.o), 0);
    check("arst_ovf16", 32'(bus16.ovf), 0);
    check("arst_wrap10", 32'(bus10.wrap), 0);
    check("arst_ovf10", 32'(bus10.ovf), 0);
    check("arst_o10", 32'(bus10.o), 0);
    tick();
    check("arst_hold", 32'(bus16.o), 0);
    #2;
    set = 1'b1;
    tick();
    check("arst_rel", 32'(bus16.o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
